// File: rtl/shift_add_multiplier.sv
// Sequential 10x10 unsigned shift-and-add multiplier: one partial-product step per
// CALC cycle, fixed 10-cycle latency, registered 20-bit product with overflow flag.
module shift_add_multiplier (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  a,
  input  logic [9:0]  b,
  output logic [19:0] product,
  output logic        ovf,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  mcand_q;
  logic [9:0]  acc_q;
  logic [9:0]  q_q;
  logic        carry_q;
  logic [3:0]  cnt_q;
  logic [19:0] product_q;
  logic        ovf_q;

  logic [10:0] sum;
  logic [9:0]  acc_shift;
  logic [9:0]  q_shift;

  // Add the multiplicand when the bit leaving Q is set, then shift {carry,acc,Q} right.
  assign sum       = {carry_q, acc_q} + {1'b0, (q_q[0] ? mcand_q : 10'd0)};
  assign acc_shift = sum[10:1];
  assign q_shift   = {sum[0], q_q[9:1]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == 4'd9) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC);
    done = (state_q == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mcand_q   <= 10'd0;
      acc_q     <= 10'd0;
      q_q       <= 10'd0;
      carry_q   <= 1'b0;
      cnt_q     <= 4'd0;
      product_q <= 20'd0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= a;
            q_q     <= b;
            acc_q   <= 10'd0;
            carry_q <= 1'b0;
            cnt_q   <= 4'd0;
          end
        end
        CALC: begin
          acc_q   <= acc_shift;
          q_q     <= q_shift;
          // The shifted-in carry position is always zero after the right shift.
          carry_q <= 1'b0;
          cnt_q   <= cnt_q + 4'd1;
          if (cnt_q == 4'd9) begin
            product_q <= {acc_shift, q_shift};
            ovf_q     <= |acc_shift;
          end
        end
        default: ;
      endcase
    end
  end

  assign product = product_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed vector table, control corner
// sequences and randomized operands against a plain a*b reference.
module tb_shift_add_multiplier;

  logic        clock;
  logic        reset;
  logic        start;
  logic [9:0]  a;
  logic [9:0]  b;
  logic [19:0] product;
  logic        ovf;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  shift_add_multiplier dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .ovf     (ovf),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [9:0]  va;
    logic [9:0]  vb;
    logic [19:0] exp_p;
    logic        exp_o;
  } vec_t;

  task automatic check(input string nm, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // Runs one operation from IDLE and returns in the IDLE cycle after DONE.
  task automatic run_op(input logic [9:0] ia, input logic [9:0] ib, input bit toggle,
                        output logic [19:0] p, output logic o, output int lat,
                        output int bcnt, output logic done_after);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (toggle) begin
        a = 10'($urandom);
        b = 10'($urandom);
      end
      @(posedge clock); #1;
      lat++;
    end
    p = product;
    o = ovf;
    @(posedge clock); #1;
    done_after = done;
  endtask

  vec_t        vecs [8];
  logic [19:0] p;
  logic        o;
  logic        dafter;
  logic [19:0] ref_p;
  int          lat;
  int          bcnt;
  int          dcnt;
  logic [19:0] seen_p;
  logic [9:0]  ra;
  logic [9:0]  rb;

  initial begin
    vecs[0] = '{10'd13,   10'd11,   20'd143,     1'b0};
    vecs[1] = '{10'd1023, 10'd1023, 20'hFF801,   1'b1};
    vecs[2] = '{10'd0,    10'd1023, 20'd0,       1'b0};
    vecs[3] = '{10'd32,   10'd32,   20'd1024,    1'b1};
    vecs[4] = '{10'd31,   10'd33,   20'd1023,    1'b0};
    vecs[5] = '{10'd1,    10'd1,    20'd1,       1'b0};
    vecs[6] = '{10'd1023, 10'd0,    20'd0,       1'b0};
    vecs[7] = '{10'd512,  10'd2,    20'd1024,    1'b1};

    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_product", product, 0);
    check("reset_ovf", ovf, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b0;

    // Directed table; the first start coincides with the first edge out of reset.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].va, vecs[i].vb, 1'b0, p, o, lat, bcnt, dafter);
      $display("vec %0d: a=%0d b=%0d product=%0d ovf=%0d latency=%0d", i,
               vecs[i].va, vecs[i].vb, p, o, lat);
      check($sformatf("vec%0d_product", i), p, vecs[i].exp_p);
      check($sformatf("vec%0d_ovf", i), o, vecs[i].exp_o);
      check($sformatf("vec%0d_latency", i), lat, 10);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, 10);
      check($sformatf("vec%0d_done_width", i), dafter, 0);
    end

    // start during CALC is ignored and not queued; product holds the old result meanwhile.
    a = 10'd5;
    b = 10'd5;
    start = 1'b1;
    @(posedge clock); #1;
    a = 10'd7;
    b = 10'd7;
    dcnt = 0;
    seen_p = '0;
    for (int k = 1; k <= 14; k++) begin
      start = (k == 3 || k == 10);
      @(posedge clock); #1;
      if (k == 3) check("hold_product_in_calc", product, 1024);
      if (done) begin
        dcnt++;
        seen_p = product;
        check("ignore_done_edge", k, 10);
      end
    end
    start = 1'b0;
    $display("ignore-start seq: done pulses=%0d product=%0d", dcnt, seen_p);
    check("ignore_done_count", dcnt, 1);
    check("ignore_product", seen_p, 25);
    check("ignore_product_held", product, 25);

    // Reset in the middle of CALC aborts with no done pulse.
    a = 10'd9;
    b = 10'd9;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_product", product, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ovf", ovf, 0);
    reset = 1'b0;
    dcnt = 0;
    repeat (15) begin
      @(posedge clock); #1;
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    run_op(10'd6, 10'd7, 1'b0, p, o, lat, bcnt, dafter);
    $display("after abort: a=6 b=7 product=%0d latency=%0d", p, lat);
    check("post_abort_product", p, 42);
    check("post_abort_latency", lat, 10);

    // Randomized operands, inputs scrambled while CALC runs.
    for (int i = 0; i < 1000; i++) begin
      ra = 10'($urandom);
      rb = 10'($urandom);
      ref_p = 20'(ra) * 20'(rb);
      run_op(ra, rb, 1'b1, p, o, lat, bcnt, dafter);
      $display("rand %0d: a=%0d b=%0d product=%0d ovf=%0d", i, ra, rb, p, o);
      check($sformatf("rand%0d_product", i), p, ref_p);
      check($sformatf("rand%0d_ovf", i), o, (ref_p > 20'd1023) ? 1 : 0);
      check($sformatf("rand%0d_latency", i), lat, 10);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
